// File: rtl/pit_timeout_sched_if.sv
// pit_timeout_sched_if: client requests plus PIT register-strobe outputs of the timeout scheduler
interface pit_timeout_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int COUNT_SIZE = 16,
  parameter int DWIDTH = 16
);
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ*COUNT_SIZE-1:0] req_cnt_i;
  logic pit_flag;
  logic [DWIDTH-1:0] write_bus;
  logic [3:0] write_regs;
  logic [NUM_REQ-1:0] active_o;
  logic [NUM_REQ-1:0] done_o;
  logic busy_o;
  modport master (output req_i, req_cnt_i, pit_flag, input write_bus, write_regs, active_o, done_o, busy_o);
  modport slave (input req_i, req_cnt_i, pit_flag, output write_bus, write_regs, active_o, done_o, busy_o);
endinterface

// File: rtl/pit_timeout_sched.sv
// pit_timeout_sched: round-robin sharing of one PIT counter between timeout requesters
module pit_timeout_sched #(
  parameter int NUM_REQ = 4,
  parameter int COUNT_SIZE = 16,
  parameter int DWIDTH = 16,
  parameter logic [3:0] PRESCALE = 4'h0,
  parameter logic IRQ_EN = 1'b0
) (
  input logic bus_clk,
  input logic sync_rst_b,
  pit_timeout_sched_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam bit W16 = (DWIDTH == 16);
  typedef enum logic [2:0] {IDLE, MOD1, MOD2, CTL1, CTL2, WAIT, STOP, ZERO} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, win;
  logic [15:0] cnt_q, cnt_d, data_d;
  logic [1:0] wait_q, wait_d;
  logic [NUM_REQ-1:0] active_q, active_d, done_q, done_d;
  logic [3:0] regs_q, regs_d;
  logic [DWIDTH-1:0] bus_q, bus_d;
  logic busy_q;
  // pick the first pending requester at or after rr_ptr; scanning downward lets the nearest one win
  always_comb begin
    win = rr_ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_i[IW'((int'(rr_ptr_q) + i) % NUM_REQ)]) win = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
  end
  // next state plus the registered outputs that belong to that next state
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    wait_d = wait_q;
    active_d = active_q;
    done_d = '0;
    case (state_q)
      IDLE: if (|bus.req_i) begin
        owner_d = win;
        cnt_d = 16'(bus.req_cnt_i[win*COUNT_SIZE +: COUNT_SIZE]);
        active_d = NUM_REQ'(1) << win;
        rr_ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        state_d = (cnt_d == 16'd0) ? ZERO : MOD1;
        done_d = (cnt_d == 16'd0) ? active_d : '0;
      end
      MOD1: state_d = W16 ? CTL2 : MOD2;
      MOD2: state_d = CTL1;
      CTL1: state_d = CTL2;
      CTL2: begin
        state_d = WAIT;
        wait_d = '0;
      end
      WAIT: begin
        wait_d = wait_q + {1'b0, wait_q != 2'd2};
        if (wait_q == 2'd2 && bus.pit_flag) begin
          state_d = STOP;
          done_d = active_q;
        end else if (!bus.req_i[owner_q]) state_d = STOP;
      end
      default: begin
        state_d = IDLE;
        active_d = '0;
      end
    endcase
    regs_d = state_d == MOD1 ? (W16 ? 4'b1100 : 4'b0100) :
             state_d == MOD2 ? 4'b1000 :
             state_d == CTL1 ? 4'b0010 :
             state_d == CTL2 ? (W16 ? 4'b0011 : 4'b0001) :
             state_d == STOP ? 4'b0001 : 4'b0000;
    data_d = state_d == MOD1 ? cnt_d :
             state_d == MOD2 ? {8'b0, cnt_d[15:8]} :
             state_d == CTL1 ? {12'b0, PRESCALE} :
             state_d == CTL2 ? (W16 ? {4'b0, PRESCALE, 5'b0, 1'b1, IRQ_EN, 1'b1} : {13'b0, 1'b1, IRQ_EN, 1'b1}) :
             state_d == STOP ? 16'h0004 : 16'h0000;
    bus_d = DWIDTH'(data_d);
  end
  // state and output registers; reset abandons any transfer without a STOP write
  always_ff @(posedge bus_clk) begin
    if (!sync_rst_b) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      owner_q <= '0;
      cnt_q <= '0;
      wait_q <= '0;
      active_q <= '0;
      done_q <= '0;
      regs_q <= '0;
      bus_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      wait_q <= wait_d;
      active_q <= active_d;
      done_q <= done_d;
      regs_q <= regs_d;
      bus_q <= bus_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign bus.write_regs = regs_q;
  assign bus.write_bus = bus_q;
  assign bus.active_o = active_q;
  assign bus.done_o = done_q;
  assign bus.busy_o = busy_q;
endmodule

// File: tb/tb_pit_timeout_sched.sv
// tb_pit_timeout_sched: directed checks of 16-bit and 8-bit scheduler instances
module tb_pit_timeout_sched;
  logic clk = 1'b0;
  logic rst_b;
  int n_cmp = 0;
  int n_err = 0;
  pit_timeout_sched_if #(.NUM_REQ(4), .COUNT_SIZE(16), .DWIDTH(16)) if16 ();
  pit_timeout_sched_if #(.NUM_REQ(4), .COUNT_SIZE(16), .DWIDTH(8)) if8 ();
  pit_timeout_sched #(.NUM_REQ(4), .COUNT_SIZE(16), .DWIDTH(16), .PRESCALE(4'h3), .IRQ_EN(1'b0))
    u16 (.bus_clk(clk), .sync_rst_b(rst_b), .bus(if16.slave));
  pit_timeout_sched #(.NUM_REQ(4), .COUNT_SIZE(16), .DWIDTH(8), .PRESCALE(4'h3), .IRQ_EN(1'b0))
    u8 (.bus_clk(clk), .sync_rst_b(rst_b), .bus(if8.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic serve(input int g);
    tick();
    check($sformatf("rr_grant%0d_active", g), 32'(if16.active_o), 32'(4'b1 << g));
    tick();
    tick();
    tick();
    tick();
    if16.pit_flag = 1'b1;
    tick();
    check($sformatf("rr_grant%0d_done", g), 32'(if16.done_o), 32'(4'b1 << g));
    check($sformatf("rr_grant%0d_stop", g), 32'(if16.write_regs), 32'h1);
    if16.pit_flag = 1'b0;
    tick();
    check($sformatf("rr_grant%0d_idle", g), 32'(if16.busy_o), 32'h0);
  endtask
  initial begin
    rst_b = 1'b0;
    if16.req_i = '0;
    if16.req_cnt_i = '0;
    if16.pit_flag = 1'b0;
    if8.req_i = '0;
    if8.req_cnt_i = '0;
    if8.pit_flag = 1'b0;
    tick();
    tick();
    check("rst_regs", 32'(if16.write_regs), 32'h0);
    check("rst_bus", 32'(if16.write_bus), 32'h0);
    check("rst_active", 32'(if16.active_o), 32'h0);
    check("rst_done", 32'(if16.done_o), 32'h0);
    check("rst_busy", 32'(if16.busy_o), 32'h0);
    check("rst8_regs", 32'(if8.write_regs), 32'h0);
    rst_b = 1'b1;
    if8.req_i = 4'b0001;
    if8.req_cnt_i[15:0] = 16'h1234;
    tick();
    check("w8_mod1_regs", 32'(if8.write_regs), 32'h4);
    check("w8_mod1_bus", 32'(if8.write_bus), 32'h34);
    check("w8_active", 32'(if8.active_o), 32'h1);
    tick();
    check("w8_mod2_regs", 32'(if8.write_regs), 32'h8);
    check("w8_mod2_bus", 32'(if8.write_bus), 32'h12);
    tick();
    check("w8_ctl1_regs", 32'(if8.write_regs), 32'h2);
    check("w8_ctl1_bus", 32'(if8.write_bus), 32'h03);
    tick();
    check("w8_ctl2_regs", 32'(if8.write_regs), 32'h1);
    check("w8_ctl2_bus", 32'(if8.write_bus), 32'h05);
    tick();
    check("w8_wait_regs", 32'(if8.write_regs), 32'h0);
    check("w8_wait_busy", 32'(if8.busy_o), 32'h1);
    if8.req_i = '0;
    tick();
    check("w8_stop_regs", 32'(if8.write_regs), 32'h1);
    check("w8_stop_bus", 32'(if8.write_bus), 32'h04);
    check("w8_cancel_done", 32'(if8.done_o), 32'h0);
    tick();
    check("w8_idle_busy", 32'(if8.busy_o), 32'h0);
    if16.req_i = 4'b0001;
    if16.req_cnt_i = {16'h0007, 16'h0006, 16'h0005, 16'h0010};
    tick();
    check("w16_mod1_regs", 32'(if16.write_regs), 32'hC);
    check("w16_mod1_bus", 32'(if16.write_bus), 32'h0010);
    check("w16_active", 32'(if16.active_o), 32'h1);
    check("w16_busy", 32'(if16.busy_o), 32'h1);
    tick();
    check("w16_ctl2_regs", 32'(if16.write_regs), 32'h3);
    check("w16_ctl2_bus", 32'(if16.write_bus), 32'h0305);
    tick();
    check("w16_wait_regs", 32'(if16.write_regs), 32'h0);
    if16.pit_flag = 1'b1;
    tick();
    check("stale_flag1_done", 32'(if16.done_o), 32'h0);
    check("stale_flag1_regs", 32'(if16.write_regs), 32'h0);
    tick();
    check("stale_flag2_done", 32'(if16.done_o), 32'h0);
    tick();
    check("w16_stop_regs", 32'(if16.write_regs), 32'h1);
    check("w16_stop_bus", 32'(if16.write_bus), 32'h0004);
    check("w16_done", 32'(if16.done_o), 32'h1);
    check("w16_stop_active", 32'(if16.active_o), 32'h1);
    if16.pit_flag = 1'b0;
    if16.req_i = '0;
    tick();
    check("w16_idle_active", 32'(if16.active_o), 32'h0);
    check("w16_idle_done", 32'(if16.done_o), 32'h0);
    check("w16_idle_busy", 32'(if16.busy_o), 32'h0);
    if16.req_i = 4'b1111;
    serve(1);
    serve(2);
    serve(3);
    serve(0);
    serve(1);
    if16.req_i = 4'b0010;
    tick();
    check("cancel_active", 32'(if16.active_o), 32'h2);
    tick();
    tick();
    if16.req_i = 4'b0000;
    tick();
    check("cancel_stop_regs", 32'(if16.write_regs), 32'h1);
    check("cancel_stop_bus", 32'(if16.write_bus), 32'h0004);
    check("cancel_done", 32'(if16.done_o), 32'h0);
    tick();
    check("cancel_idle", 32'(if16.busy_o), 32'h0);
    if16.req_i = 4'b0010;
    tick();
    tick();
    tick();
    tick();
    tick();
    if16.pit_flag = 1'b1;
    if16.req_i = 4'b0000;
    tick();
    check("flag_wins_done", 32'(if16.done_o), 32'h2);
    check("flag_wins_regs", 32'(if16.write_regs), 32'h1);
    if16.pit_flag = 1'b0;
    tick();
    if16.req_i = 4'b0100;
    if16.req_cnt_i[47:32] = 16'h0000;
    tick();
    check("zero_regs", 32'(if16.write_regs), 32'h0);
    check("zero_done", 32'(if16.done_o), 32'h4);
    check("zero_active", 32'(if16.active_o), 32'h4);
    check("zero_busy", 32'(if16.busy_o), 32'h1);
    if16.req_i = 4'b0000;
    tick();
    check("zero_idle_busy", 32'(if16.busy_o), 32'h0);
    check("zero_idle_done", 32'(if16.done_o), 32'h0);
    check("zero_idle_regs", 32'(if16.write_regs), 32'h0);
    if16.req_i = 4'b0001;
    tick();
    check("pre_rst_active", 32'(if16.active_o), 32'h1);
    tick();
    tick();
    rst_b = 1'b0;
    tick();
    check("midrst_regs", 32'(if16.write_regs), 32'h0);
    check("midrst_bus", 32'(if16.write_bus), 32'h0);
    check("midrst_active", 32'(if16.active_o), 32'h0);
    check("midrst_done", 32'(if16.done_o), 32'h0);
    check("midrst_busy", 32'(if16.busy_o), 32'h0);
    rst_b = 1'b1;
    if16.req_i = 4'b1010;
    tick();
    check("post_rst_grant", 32'(if16.active_o), 32'h2);
    check("post_rst_regs", 32'(if16.write_regs), 32'hC);
    if16.req_i = 4'b0000;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
